// File: rtl/sixbitkeyin.sv
// sixbitkeyin: keypad operand-entry stage for the six-bit calculator datapath.
//
// Accumulates key digits into a 6-bit unsigned operand. On ENTER it presents
// the operand downstream over a valid/ready handshake. Any accumulation that
// would exceed 63 is trapped in an error state until CLEAR.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous reset, active low
//   key_valid   key_code is valid this cycle
//   key_code    5-bit key code (0x00-0x0F digits, 0x10 CLEAR, 0x11 BACKSPACE,
//               0x12 ENTER, 0x13 RADIX, other codes ignored)
//   key_ready   a key is accepted this cycle (low while an operand is pending)
//   acc         live accumulator value for the display
//   opnd        operand presented to the function unit
//   opnd_valid  opnd is valid
//   opnd_ready  function unit accepts opnd
//   err         accumulation overflowed; only CLEAR is acted on
//   hex_mode    current radix is 16
//
// Build option: define SIXBITKEYIN_HEX_EN to enable the RADIX key and hex
// digits. Without it the radix is fixed at 10 and hex_mode is tied low.
module sixbitkeyin (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_valid,
   input  logic [4:0] key_code,
   output logic       key_ready,
   output logic [5:0] acc,
   output logic [5:0] opnd,
   output logic       opnd_valid,
   input  logic       opnd_ready,
   output logic       err,
   output logic       hex_mode
);
   localparam logic [4:0] K_CLEAR = 5'h10;
   localparam logic [4:0] K_BACK  = 5'h11;
   localparam logic [4:0] K_ENTER = 5'h12;
   // One-hot so that opnd_valid and err come straight off a state flop.
   typedef enum logic [2:0] {ENTRY = 3'b001, SEND = 3'b010, ERR = 3'b100} state_t;
   state_t     state, state_nxt;
   logic [5:0] acc_nxt, opnd_nxt;
   logic       take, is_digit;
   logic [9:0] grown;
   logic [5:0] shrunk;
`ifdef SIXBITKEYIN_HEX_EN
   localparam logic [4:0] K_RADIX = 5'h13;
   logic hex_q, hex_nxt;
   assign is_digit = !key_code[4] && (hex_q || key_code[3:0] < 4'd10);
   assign grown    = (hex_q ? {acc, 4'b0000} : 10'(acc) * 10'd10) + 10'(key_code[3:0]);
   assign shrunk   = hex_q ? acc >> 4 : acc / 6'd10;
`else
   assign is_digit = !key_code[4] && key_code[3:0] < 4'd10;
   assign grown    = 10'(acc) * 10'd10 + 10'(key_code[3:0]);
   assign shrunk   = acc / 6'd10;
`endif
   assign take = key_valid && key_ready;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ENTRY;
         acc   <= '0;
         opnd  <= '0;
`ifdef SIXBITKEYIN_HEX_EN
         hex_q <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         acc   <= acc_nxt;
         opnd  <= opnd_nxt;
`ifdef SIXBITKEYIN_HEX_EN
         hex_q <= hex_nxt;
`endif
      end
   end
   always_comb begin
      state_nxt = state;
      acc_nxt   = acc;
      opnd_nxt  = opnd;
`ifdef SIXBITKEYIN_HEX_EN
      hex_nxt   = hex_q;
`endif
      case (state)
         ENTRY: if (take) begin
            // An overflowing digit leaves acc at its last valid value.
            if (is_digit) begin
               if (grown > 10'd63) state_nxt = ERR;
               else acc_nxt = grown[5:0];
            end else if (key_code == K_CLEAR) acc_nxt = '0;
            else if (key_code == K_BACK) acc_nxt = shrunk;
            else if (key_code == K_ENTER) begin
               opnd_nxt  = acc;
               state_nxt = SEND;
            end
`ifdef SIXBITKEYIN_HEX_EN
            else if (key_code == K_RADIX) hex_nxt = !hex_q;
`endif
         end
         SEND: if (opnd_ready) begin
            acc_nxt   = '0;
            state_nxt = ENTRY;
         end
         ERR: if (take && key_code == K_CLEAR) begin
            acc_nxt   = '0;
            state_nxt = ENTRY;
         end
         default: state_nxt = ENTRY;
      endcase
   end
   always_comb begin
      key_ready  = state != SEND;
      opnd_valid = state[1];
      err        = state[2];
`ifdef SIXBITKEYIN_HEX_EN
      hex_mode   = hex_q;
`else
      hex_mode   = 1'b0;
`endif
   end
endmodule

// File: tb/tb_sixbitkeyin.sv
// tb_sixbitkeyin: directed self-checking bench for sixbitkeyin.
module tb_sixbitkeyin;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       key_valid = 1'b0;
   logic [4:0] key_code = '0;
   logic       key_ready;
   logic [5:0] acc, opnd;
   logic       opnd_valid;
   logic       opnd_ready = 1'b0;
   logic       err, hex_mode;
   int         checks = 0;
   int         failures = 0;

   localparam logic [4:0] K_CLEAR = 5'h10;
   localparam logic [4:0] K_BACK  = 5'h11;
   localparam logic [4:0] K_ENTER = 5'h12;
   localparam logic [4:0] K_RADIX = 5'h13;

   sixbitkeyin dut (
      .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
      .key_ready(key_ready), .acc(acc), .opnd(opnd), .opnd_valid(opnd_valid),
      .opnd_ready(opnd_ready), .err(err), .hex_mode(hex_mode)
   );

   always #5 clk = ~clk;

   // Presents one key for one cycle; returns 1 ns after the sampling edge.
   task automatic press(input logic [4:0] code);
      @(negedge clk);
      key_valid = 1'b1;
      key_code  = code;
      @(posedge clk);
      #1 key_valid = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      checks++; if (acc !== 6'd0) begin failures++; $display("FAIL reset_acc: got %0d expected 0", acc); end
      checks++; if (opnd !== 6'd0) begin failures++; $display("FAIL reset_opnd: got %0d expected 0", opnd); end
      checks++; if (opnd_valid !== 1'b0) begin failures++; $display("FAIL reset_opnd_valid: got %b expected 0", opnd_valid); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", err); end
      checks++; if (hex_mode !== 1'b0) begin failures++; $display("FAIL reset_hex_mode: got %b expected 0", hex_mode); end
      checks++; if (key_ready !== 1'b1) begin failures++; $display("FAIL reset_key_ready: got %b expected 1", key_ready); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      opnd_ready = 1'b1;
      press(5'h04);
      checks++; if (acc !== 6'd4) begin failures++; $display("FAIL basic_acc4: got %0d expected 4", acc); end
      press(5'h02);
      checks++; if (acc !== 6'd42) begin failures++; $display("FAIL basic_acc42: got %0d expected 42", acc); end
      press(K_ENTER);
      checks++; if (opnd_valid !== 1'b1) begin failures++; $display("FAIL basic_valid_hi: got %b expected 1", opnd_valid); end
      checks++; if (opnd !== 6'd42) begin failures++; $display("FAIL basic_opnd: got %0d expected 42", opnd); end
      checks++; if (key_ready !== 1'b0) begin failures++; $display("FAIL basic_key_ready_lo: got %b expected 0", key_ready); end
      tick();
      checks++; if (opnd_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_one_cycle: got %b expected 0", opnd_valid); end
      checks++; if (acc !== 6'd0) begin failures++; $display("FAIL basic_acc_cleared: got %0d expected 0", acc); end
      checks++; if (key_ready !== 1'b1) begin failures++; $display("FAIL basic_key_ready_hi: got %b expected 1", key_ready); end
   endtask

   task automatic test_boundary();
      opnd_ready = 1'b1;
      press(5'h06);
      press(5'h03);
      checks++; if (acc !== 6'd63 || err !== 1'b0) begin failures++; $display("FAIL bound_acc63: got acc=%0d err=%b expected acc=63 err=0", acc, err); end
      press(5'h1F);
      checks++; if (acc !== 6'd63 || err !== 1'b0) begin failures++; $display("FAIL bound_ignored_code: got acc=%0d err=%b expected acc=63 err=0", acc, err); end
      press(K_ENTER);
      checks++; if (opnd !== 6'd63 || opnd_valid !== 1'b1) begin failures++; $display("FAIL bound_opnd63: got opnd=%0d valid=%b expected opnd=63 valid=1", opnd, opnd_valid); end
      tick();
   endtask

   task automatic test_overflow();
      opnd_ready = 1'b1;
      press(5'h06);
      press(5'h04);
      checks++; if (err !== 1'b1) begin failures++; $display("FAIL ovf_err: got %b expected 1", err); end
      checks++; if (acc !== 6'd6) begin failures++; $display("FAIL ovf_acc_hold: got %0d expected 6", acc); end
      press(5'h03);
      checks++; if (acc !== 6'd6 || err !== 1'b1) begin failures++; $display("FAIL ovf_digit_ignored: got acc=%0d err=%b expected acc=6 err=1", acc, err); end
      press(K_ENTER);
      checks++; if (opnd_valid !== 1'b0 || err !== 1'b1) begin failures++; $display("FAIL ovf_enter_ignored: got valid=%b err=%b expected valid=0 err=1", opnd_valid, err); end
      press(K_CLEAR);
      checks++; if (err !== 1'b0 || acc !== 6'd0) begin failures++; $display("FAIL ovf_clear: got err=%b acc=%0d expected err=0 acc=0", err, acc); end
   endtask

   task automatic test_stall();
      opnd_ready = 1'b0;
      press(5'h05);
      press(5'h09);
      checks++; if (acc !== 6'd59) begin failures++; $display("FAIL stall_acc59: got %0d expected 59", acc); end
      press(K_BACK);
      checks++; if (acc !== 6'd5) begin failures++; $display("FAIL stall_backspace: got %0d expected 5", acc); end
      press(K_ENTER);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         key_valid = 1'b1;
         key_code  = 5'h07;
         tick();
         checks++; if (opnd_valid !== 1'b1 || opnd !== 6'd5 || key_ready !== 1'b0 || acc !== 6'd5) begin
            failures++;
            $display("FAIL stall_hold%0d: got valid=%b opnd=%0d ready=%b acc=%0d expected valid=1 opnd=5 ready=0 acc=5", i, opnd_valid, opnd, key_ready, acc);
         end
      end
      @(negedge clk);
      key_valid  = 1'b0;
      opnd_ready = 1'b1;
      tick();
      checks++; if (opnd_valid !== 1'b0 || acc !== 6'd0 || key_ready !== 1'b1) begin failures++; $display("FAIL stall_transfer: got valid=%b acc=%0d ready=%b expected valid=0 acc=0 ready=1", opnd_valid, acc, key_ready); end
   endtask

   task automatic test_reset_mid_send();
      opnd_ready = 1'b0;
      press(5'h07);
      press(K_ENTER);
      checks++; if (opnd_valid !== 1'b1 || opnd !== 6'd7) begin failures++; $display("FAIL rst_send_pending: got valid=%b opnd=%0d expected valid=1 opnd=7", opnd_valid, opnd); end
      #3 rst_n = 1'b0;
      #1;
      checks++; if (opnd_valid !== 1'b0 || opnd !== 6'd0 || acc !== 6'd0 || err !== 1'b0 || key_ready !== 1'b1 || hex_mode !== 1'b0) begin
         failures++;
         $display("FAIL rst_async: got valid=%b opnd=%0d acc=%0d err=%b ready=%b hex=%b expected 0 0 0 0 1 0", opnd_valid, opnd, acc, err, key_ready, hex_mode);
      end
      @(negedge clk);
      rst_n = 1'b1;
      opnd_ready = 1'b1;
      press(K_ENTER);
      checks++; if (opnd_valid !== 1'b1 || opnd !== 6'd0) begin failures++; $display("FAIL rst_enter_zero: got valid=%b opnd=%0d expected valid=1 opnd=0", opnd_valid, opnd); end
      tick();
      checks++; if (opnd_valid !== 1'b0) begin failures++; $display("FAIL rst_zero_transfer: got %b expected 0", opnd_valid); end
   endtask

`ifdef SIXBITKEYIN_HEX_EN
   task automatic test_hex();
      opnd_ready = 1'b1;
      press(K_RADIX);
      checks++; if (hex_mode !== 1'b1) begin failures++; $display("FAIL hex_mode_on: got %b expected 1", hex_mode); end
      press(5'h03);
      press(5'h0F);
      checks++; if (acc !== 6'd63) begin failures++; $display("FAIL hex_acc3f: got %0d expected 63", acc); end
      press(K_ENTER);
      checks++; if (opnd !== 6'd63 || opnd_valid !== 1'b1) begin failures++; $display("FAIL hex_opnd: got opnd=%0d valid=%b expected opnd=63 valid=1", opnd, opnd_valid); end
      tick();
      press(K_RADIX);
      checks++; if (hex_mode !== 1'b0) begin failures++; $display("FAIL hex_mode_off: got %b expected 0", hex_mode); end
      press(5'h0A);
      checks++; if (acc !== 6'd0) begin failures++; $display("FAIL hex_a_ignored: got %0d expected 0", acc); end
   endtask
`else
   task automatic test_no_hex();
      opnd_ready = 1'b1;
      press(K_RADIX);
      checks++; if (hex_mode !== 1'b0) begin failures++; $display("FAIL nohex_mode: got %b expected 0", hex_mode); end
      press(5'h0B);
      checks++; if (acc !== 6'd0) begin failures++; $display("FAIL nohex_b_ignored: got %0d expected 0", acc); end
      press(5'h01);
      press(K_ENTER);
      checks++; if (opnd !== 6'd1 || opnd_valid !== 1'b1) begin failures++; $display("FAIL nohex_opnd: got opnd=%0d valid=%b expected opnd=1 valid=1", opnd, opnd_valid); end
      tick();
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_boundary();
      test_overflow();
      test_stall();
      test_reset_mid_send();
`ifdef SIXBITKEYIN_HEX_EN
      test_hex();
`else
      test_no_hex();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
